lc_request_sequencer: RTL and testbench
=======================================

Name: lc_request_sequencer

Overview:
- Upstream front-end for the MCSE top-level lifecycle inputs.
- Accepts a 32-bit word/command stream from the host (debug/GPIO bridge) over a valid/ready handshake.
- Assembles the 256-bit lifecycle transition ID, then the 256-bit authentication ID.
- Drives lc_transition_id, lc_transition_request_in, lc_authentication_id and lc_authentication_valid into the MCSE top, with abort, protocol-error and timeout handling.

Parameters:
- WORD_W, 32, host data word width.
- ID_W, 256, width of each ID; WORDS = ID_W/WORD_W = 8.
- TIMEOUT_CYCLES, 1024, maximum cycles allowed between authentication words while armed.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- host_valid  input  1  host word/command valid.
- host_ready  output  1  sequencer can accept; a transfer occurs when host_valid&host_ready.
- host_cmd  input  2  00 DATA, 01 START, 10 reserved, 11 ABORT.
- host_data  input  WORD_W  payload; used only with DATA.
- lc_transition_id  output  ID_W  assembled transition ID, to MCSE lc_transition_id.
- lc_transition_request_in  output  1  transition request level, to MCSE.
- lc_authentication_id  output  ID_W  assembled authentication ID.
- lc_authentication_valid  output  1  one-cycle authentication strobe.
- seq_busy  output  1  state != IDLE.
- seq_error  output  1  sticky error flag; cleared by rst or an accepted START.
- seq_state  output  3  state encoding, for debug.

Behaviour:
- Reset (rst high at a clk edge):
  - State returns to IDLE.
  - Both ID registers, the word counter, the timer and seq_error are cleared to 0.
  - All outputs read 0 in the following cycle.
  - host_ready is combinationally forced to 0 while rst is high.
  - Reset mid-sequence abandons the sequence with no strobe.
- State encoding: IDLE=0, LOAD_TID=1, ARMED=2, AUTH=3.
- Status and handshake decodes:
  - lc_transition_request_in = (state==ARMED || state==AUTH).
  - lc_authentication_valid = (state==AUTH).
  - host_ready = !rst && state!=AUTH.
  - All four are decodes of the state register only; no combinational path from host inputs.
- ID assembly: on each accepted DATA word, id_reg <= {id_reg[ID_W-WORD_W-1:0], host_data}. The first word therefore ends in bits [255:224].
- Word counter: 3 bits; the 8th word is accepted when cnt==7.
- IDLE:
  - START: clear transition-ID reg, auth-ID reg, cnt and seq_error; go to LOAD_TID.
  - DATA or reserved: set seq_error, stay in IDLE.
  - ABORT: no effect.
- LOAD_TID:
  - DATA: shift into the transition-ID reg; cnt++. On the 8th word go to ARMED, clear cnt, clear timer.
  - START: clear transition-ID reg and cnt; stay (restart).
  - ABORT: go to IDLE; no error.
  - Reserved: set seq_error, go to IDLE.
  - No timeout in this state.
- ARMED:
  - Request is high from the first ARMED cycle, i.e. the cycle after the 8th transition-ID handshake.
  - Timer increments each cycle with no accepted DATA word and resets on each accepted DATA word.
  - DATA: shift into the auth-ID reg; cnt++. On the 8th word go to AUTH.
  - Timer reaching TIMEOUT_CYCLES-1 with no word accepted that cycle: set seq_error, go to IDLE.
  - If a word is accepted in the expiry cycle, the word wins.
  - ABORT: go to IDLE; no error.
  - START or reserved: set seq_error, go to IDLE.
- AUTH:
  - Exactly one cycle: lc_authentication_valid=1, request still 1, host_ready=0.
  - Unconditionally go to IDLE.
  - Request and valid fall together.
- ID retention: ID outputs hold their last assembled values after IDLE until the next START, which clears them. The ID outputs are stable throughout ARMED/AUTH.
- seq_error is sticky across ABORT and across further invalid commands.
- Throughput: one transfer per cycle is accepted with host_valid held high. Minimum sequence is 1 START + 16 DATA + 1 AUTH cycle = 18 cycles.

Test Plan:
- Nominal: START, then DATA 0x00000001..0x00000008, then DATA 0xA0000001..0xA0000008, back-to-back -> lc_transition_id=0x00000001_00000002_..._00000008; request high from the cycle after word 8 through the AUTH cycle; lc_authentication_id=0xA0000001_..._A0000008; valid high for exactly 1 cycle, coinciding with the request's last high cycle; seq_error=0.
- Timeout: START, 8 TID words, 3 auth words, then host_valid=0 for TIMEOUT_CYCLES cycles -> seq_error=1, request drops, valid never asserts, state=IDLE. Repeat with a word arriving in the expiry cycle -> no error.
- Abort: ABORT after 5 TID words -> IDLE, request never asserts, seq_error=0. ABORT in ARMED after 4 auth words -> request drops the next cycle, no strobe.
- Protocol errors: DATA in IDLE -> seq_error=1, stays IDLE. A following START -> seq_error=0. START in ARMED -> seq_error=1, IDLE.
- Backpressure/restart: host_valid toggling every other cycle yields correct IDs. START after 3 TID words clears cnt, and the next 8 words form the ID. host_valid held during AUTH is not accepted (host_ready=0).
- Reset: rst asserted in ARMED after 2 auth words -> next cycle all outputs 0 and host_ready=0 while rst is high. After release, host_ready=1 and state=IDLE.

Source files
------------

// File: rtl/lc_request_sequencer.sv
// Host-side front-end for the MCSE lifecycle inputs: assembles the transition ID and
// the authentication ID from a 32-bit word/command stream and sequences request/strobe.
module lc_request_sequencer #(
    parameter int WORD_W         = 32,
    parameter int ID_W           = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [1:0]        host_cmd,
    input  logic [WORD_W-1:0] host_data,
    output logic [ID_W-1:0]   lc_transition_id,
    output logic              lc_transition_request_in,
    output logic [ID_W-1:0]   lc_authentication_id,
    output logic              lc_authentication_valid,
    output logic              seq_busy,
    output logic              seq_error,
    output logic [2:0]        seq_state
);

    localparam int WORDS = ID_W / WORD_W;
    localparam int CNT_W = $clog2(WORDS);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] CMD_DATA  = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_TID = 3'd1,
        ARMED    = 3'd2,
        AUTH     = 3'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ID_W-1:0]   tid_r;
    logic [ID_W-1:0]   aid_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [TMR_W-1:0]  timer_r;
    logic              err_r;

    logic fire_s;
    logic last_word_s;
    logic timer_exp_s;
    logic clr_tid_s;
    logic clr_aid_s;
    logic shift_tid_s;
    logic shift_aid_s;
    logic cnt_inc_s;
    logic cnt_clr_s;
    logic tmr_inc_s;
    logic tmr_clr_s;
    logic set_err_s;
    logic clr_err_s;

    // Handshake and status are pure decodes of the state register (plus rst gating ready).
    assign host_ready               = !rst && (state_r != AUTH);
    assign lc_transition_request_in = (state_r == ARMED) || (state_r == AUTH);
    assign lc_authentication_valid  = (state_r == AUTH);
    assign seq_busy                 = (state_r != IDLE);
    assign seq_state                = state_r;
    assign seq_error                = err_r;
    assign lc_transition_id         = tid_r;
    assign lc_authentication_id     = aid_r;

    assign fire_s      = host_valid && host_ready;
    assign last_word_s = (cnt_r == CNT_W'(WORDS - 1));
    assign timer_exp_s = (timer_r == TMR_W'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_s     = state_r;
        clr_tid_s   = 1'b0;
        clr_aid_s   = 1'b0;
        shift_tid_s = 1'b0;
        shift_aid_s = 1'b0;
        cnt_inc_s   = 1'b0;
        cnt_clr_s   = 1'b0;
        tmr_inc_s   = 1'b0;
        tmr_clr_s   = 1'b0;
        set_err_s   = 1'b0;
        clr_err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (fire_s) begin
                    case (host_cmd)
                        CMD_START: begin
                            state_s   = LOAD_TID;
                            clr_tid_s = 1'b1;
                            clr_aid_s = 1'b1;
                            cnt_clr_s = 1'b1;
                            clr_err_s = 1'b1;
                        end
                        CMD_ABORT: state_s = IDLE;
                        default:   set_err_s = 1'b1;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD_TID: begin
                if (fire_s) begin
                    case (host_cmd)
                        CMD_DATA: begin
                            shift_tid_s = 1'b1;
                            if (last_word_s) begin
                                state_s   = ARMED;
                                cnt_clr_s = 1'b1;
                                tmr_clr_s = 1'b1;
                            end else begin
                                cnt_inc_s = 1'b1;
                            end
                        end
                        CMD_START: begin
                            clr_tid_s = 1'b1;
                            cnt_clr_s = 1'b1;
                            clr_err_s = 1'b1;
                        end
                        CMD_ABORT: state_s = IDLE;
                        default: begin
                            set_err_s = 1'b1;
                            state_s   = IDLE;
                        end
                    endcase
                end else begin
                    state_s = LOAD_TID;
                end
            end
            ARMED: begin
                // An accepted word in the expiry cycle takes priority over the timeout.
                if (fire_s) begin
                    case (host_cmd)
                        CMD_DATA: begin
                            shift_aid_s = 1'b1;
                            tmr_clr_s   = 1'b1;
                            if (last_word_s) begin
                                state_s   = AUTH;
                                cnt_clr_s = 1'b1;
                            end else begin
                                cnt_inc_s = 1'b1;
                            end
                        end
                        CMD_ABORT: state_s = IDLE;
                        default: begin
                            set_err_s = 1'b1;
                            state_s   = IDLE;
                        end
                    endcase
                end else if (timer_exp_s) begin
                    set_err_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    tmr_inc_s = 1'b1;
                end
            end
            AUTH:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // ID registers, word counter, inter-word timer and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            tid_r   <= '0;
            aid_r   <= '0;
            cnt_r   <= '0;
            timer_r <= '0;
            err_r   <= 1'b0;
        end else begin
            if (clr_tid_s) begin
                tid_r <= '0;
            end else if (shift_tid_s) begin
                tid_r <= {tid_r[ID_W-WORD_W-1:0], host_data};
            end else begin
                tid_r <= tid_r;
            end
            if (clr_aid_s) begin
                aid_r <= '0;
            end else if (shift_aid_s) begin
                aid_r <= {aid_r[ID_W-WORD_W-1:0], host_data};
            end else begin
                aid_r <= aid_r;
            end
            if (cnt_clr_s) begin
                cnt_r <= '0;
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (tmr_clr_s) begin
                timer_r <= '0;
            end else if (tmr_inc_s) begin
                timer_r <= timer_r + TMR_W'(1);
            end else begin
                timer_r <= timer_r;
            end
            if (set_err_s) begin
                err_r <= 1'b1;
            end else if (clr_err_s) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

endmodule

// File: tb/tb_lc_request_sequencer.sv
// Scenario-driven bench: expected ID pairs are queued as sequences are driven and
// popped when the authentication strobe appears; tasks check status inline.
module tb_lc_request_sequencer;

    localparam int TOUT = 1024;
    localparam logic [1:0] C_DATA  = 2'b00;
    localparam logic [1:0] C_START = 2'b01;
    localparam logic [1:0] C_RSVD  = 2'b10;
    localparam logic [1:0] C_ABORT = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         host_valid = 1'b0;
    logic         host_ready;
    logic [1:0]   host_cmd = 2'b00;
    logic [31:0]  host_data = 32'h0;
    logic [255:0] lc_transition_id;
    logic         lc_transition_request_in;
    logic [255:0] lc_authentication_id;
    logic         lc_authentication_valid;
    logic         seq_busy;
    logic         seq_error;
    logic [2:0]   seq_state;

    typedef struct packed {
        logic [255:0] tid;
        logic [255:0] aid;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    lc_request_sequencer #(.WORD_W(32), .ID_W(256), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .host_valid               (host_valid),
        .host_ready               (host_ready),
        .host_cmd                 (host_cmd),
        .host_data                (host_data),
        .lc_transition_id         (lc_transition_id),
        .lc_transition_request_in (lc_transition_request_in),
        .lc_authentication_id     (lc_authentication_id),
        .lc_authentication_valid  (lc_authentication_valid),
        .seq_busy                 (seq_busy),
        .seq_error                (seq_error),
        .seq_state                (seq_state)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mk_id(input logic [31:0] base);
        logic [255:0] id = 256'h0;
        for (int i = 1; i <= 8; i++) id = {id[223:0], base + 32'(i)};
        return id;
    endfunction

    // Scoreboard: every strobe must match the oldest queued sequence.
    always @(negedge clk) begin
        if (!rst && lc_authentication_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL strobe_unexpected: got strobe, required none");
            end else begin
                exp_t e;
                n_pass++;
                e = exp_q.pop_front();
                n_checks++;
                if (lc_transition_id !== e.tid)
                    $display("FAIL sb_tid: got %h required %h", lc_transition_id, e.tid);
                else n_pass++;
                n_checks++;
                if (lc_authentication_id !== e.aid)
                    $display("FAIL sb_aid: got %h required %h", lc_authentication_id, e.aid);
                else n_pass++;
            end
        end
    end

    task automatic send(input logic [1:0] c, input logic [31:0] d);
        host_valid = 1'b1; host_cmd = c; host_data = d;
        @(posedge clk); #1;
        host_valid = 1'b0; host_cmd = C_DATA; host_data = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_words(input logic [31:0] base, input int n, input bit gap);
        for (int i = 1; i <= n; i++) begin
            send(C_DATA, base + 32'(i));
            if (gap) idle(1);
        end
    endtask

    task automatic test_reset;
        idle(3);
        n_checks++;
        if ({host_ready, lc_transition_request_in, lc_authentication_valid, seq_busy, seq_error, seq_state} !== 8'h00
            || lc_transition_id !== 256'h0 || lc_authentication_id !== 256'h0)
            $display("FAIL reset_outputs: ready=%b req=%b err=%b state=%0d", host_ready, lc_transition_request_in, seq_error, seq_state);
        else n_pass++;
        rst = 1'b0; #1;
        n_checks++;
        if ({host_ready, seq_state} !== {1'b1, 3'd0})
            $display("FAIL reset_release: ready=%b state=%0d required 1/0", host_ready, seq_state);
        else n_pass++;
    endtask

    task automatic test_nominal;
        exp_q.push_back({256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008,
                         256'hA0000001_A0000002_A0000003_A0000004_A0000005_A0000006_A0000007_A0000008});
        send(C_START, 32'h0);
        send_words(32'h0, 7, 1'b0);
        n_checks++;
        if ({lc_transition_request_in, seq_state} !== {1'b0, 3'd1})
            $display("FAIL nom_load: req=%b state=%0d required 0/1", lc_transition_request_in, seq_state);
        else n_pass++;
        send(C_DATA, 32'h8);
        n_checks++;
        if ({lc_transition_request_in, lc_authentication_valid, seq_state} !== {1'b1, 1'b0, 3'd2})
            $display("FAIL nom_armed: req=%b val=%b state=%0d required 1/0/2", lc_transition_request_in, lc_authentication_valid, seq_state);
        else n_pass++;
        n_checks++;
        if (lc_transition_id !== 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008)
            $display("FAIL nom_tid: got %h", lc_transition_id);
        else n_pass++;
        send_words(32'hA0000000, 8, 1'b0);
        n_checks++;
        if ({lc_transition_request_in, lc_authentication_valid, host_ready, seq_state} !== {1'b1, 1'b1, 1'b0, 3'd3})
            $display("FAIL nom_auth: req=%b val=%b ready=%b state=%0d required 1/1/0/3", lc_transition_request_in, lc_authentication_valid, host_ready, seq_state);
        else n_pass++;
        idle(1);
        n_checks++;
        if ({lc_transition_request_in, lc_authentication_valid, seq_error, seq_busy, seq_state} !== 7'b0)
            $display("FAIL nom_done: req=%b val=%b err=%b state=%0d required all 0", lc_transition_request_in, lc_authentication_valid, seq_error, seq_state);
        else n_pass++;
        n_checks++;
        if (lc_authentication_id !== 256'hA0000001_A0000002_A0000003_A0000004_A0000005_A0000006_A0000007_A0000008)
            $display("FAIL nom_aid_hold: got %h", lc_authentication_id);
        else n_pass++;
    endtask

    task automatic test_timeout;
        send(C_START, 32'h0);
        send_words(32'h10000000, 8, 1'b0);
        send_words(32'h20000000, 3, 1'b0);
        idle(TOUT - 1);
        n_checks++;
        if ({lc_transition_request_in, seq_error, seq_state} !== {1'b1, 1'b0, 3'd2})
            $display("FAIL tout_early: req=%b err=%b state=%0d required 1/0/2", lc_transition_request_in, seq_error, seq_state);
        else n_pass++;
        idle(1);
        n_checks++;
        if ({lc_transition_request_in, seq_error, seq_state} !== {1'b0, 1'b1, 3'd0})
            $display("FAIL tout_expire: req=%b err=%b state=%0d required 0/1/0", lc_transition_request_in, seq_error, seq_state);
        else n_pass++;
        // word lands exactly in the expiry cycle
        exp_q.push_back({mk_id(32'h30000000), mk_id(32'h40000000)});
        send(C_START, 32'h0);
        send_words(32'h30000000, 8, 1'b0);
        send_words(32'h40000000, 3, 1'b0);
        idle(TOUT - 1);
        send(C_DATA, 32'h40000004);
        n_checks++;
        if ({seq_error, seq_state} !== {1'b0, 3'd2})
            $display("FAIL tout_word_wins: err=%b state=%0d required 0/2", seq_error, seq_state);
        else n_pass++;
        for (int i = 5; i <= 8; i++) send(C_DATA, 32'h40000000 + 32'(i));
        idle(1);
        n_checks++;
        if ({seq_error, seq_state} !== {1'b0, 3'd0})
            $display("FAIL tout_word_done: err=%b state=%0d required 0/0", seq_error, seq_state);
        else n_pass++;
    endtask

    task automatic test_abort;
        send(C_START, 32'h0);
        send_words(32'h50000000, 5, 1'b0);
        send(C_ABORT, 32'h0);
        n_checks++;
        if ({lc_transition_request_in, seq_error, seq_state} !== {1'b0, 1'b0, 3'd0})
            $display("FAIL abort_load: req=%b err=%b state=%0d required 0/0/0", lc_transition_request_in, seq_error, seq_state);
        else n_pass++;
        send(C_START, 32'h0);
        send_words(32'h60000000, 8, 1'b0);
        send_words(32'h70000000, 4, 1'b0);
        send(C_ABORT, 32'h0);
        n_checks++;
        if ({lc_transition_request_in, lc_authentication_valid, seq_error, seq_state} !== 6'b0)
            $display("FAIL abort_armed: req=%b val=%b err=%b state=%0d required all 0", lc_transition_request_in, lc_authentication_valid, seq_error, seq_state);
        else n_pass++;
    endtask

    task automatic test_protocol;
        send(C_DATA, 32'h1234);
        n_checks++;
        if ({seq_error, seq_state} !== {1'b1, 3'd0})
            $display("FAIL perr_idle_data: err=%b state=%0d required 1/0", seq_error, seq_state);
        else n_pass++;
        send(C_ABORT, 32'h0);
        send(C_RSVD, 32'h0);
        n_checks++;
        if ({seq_error, seq_state} !== {1'b1, 3'd0})
            $display("FAIL perr_sticky: err=%b state=%0d required 1/0", seq_error, seq_state);
        else n_pass++;
        send(C_START, 32'h0);
        n_checks++;
        if ({seq_error, seq_state} !== {1'b0, 3'd1})
            $display("FAIL perr_start_clear: err=%b state=%0d required 0/1", seq_error, seq_state);
        else n_pass++;
        send_words(32'h80000000, 8, 1'b0);
        send(C_START, 32'h0);
        n_checks++;
        if ({lc_transition_request_in, seq_error, seq_state} !== {1'b0, 1'b1, 3'd0})
            $display("FAIL perr_armed_start: req=%b err=%b state=%0d required 0/1/0", lc_transition_request_in, seq_error, seq_state);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        exp_q.push_back({mk_id(32'hB0000000), mk_id(32'hC0000000)});
        send(C_START, 32'h0);
        send_words(32'h90000000, 3, 1'b0);
        send(C_START, 32'h0);
        n_checks++;
        if ({seq_error, seq_state, lc_transition_id} !== {1'b0, 3'd1, 256'h0})
            $display("FAIL restart_clear: err=%b state=%0d tid=%h", seq_error, seq_state, lc_transition_id);
        else n_pass++;
        send_words(32'hB0000000, 8, 1'b1);
        send_words(32'hC0000000, 7, 1'b1);
        send(C_DATA, 32'hC0000008);
        // host holds a word through the AUTH cycle; it must not be taken
        host_valid = 1'b1; host_cmd = C_DATA; host_data = 32'hDEADBEEF;
        #1;
        n_checks++;
        if ({host_ready, lc_authentication_valid} !== 2'b01)
            $display("FAIL auth_ready: ready=%b val=%b required 0/1", host_ready, lc_authentication_valid);
        else n_pass++;
        @(posedge clk); #1;
        host_valid = 1'b0;
        n_checks++;
        if ({seq_error, seq_state, lc_authentication_id} !== {1'b0, 3'd0, mk_id(32'hC0000000)})
            $display("FAIL auth_hold_word: err=%b state=%0d aid=%h", seq_error, seq_state, lc_authentication_id);
        else n_pass++;
    endtask

    task automatic test_midseq_reset;
        send(C_START, 32'h0);
        send_words(32'hD0000000, 8, 1'b0);
        send_words(32'hE0000000, 2, 1'b0);
        rst = 1'b1;
        idle(1);
        n_checks++;
        if ({host_ready, lc_transition_request_in, lc_authentication_valid, seq_busy, seq_error, seq_state} !== 8'h00
            || lc_transition_id !== 256'h0 || lc_authentication_id !== 256'h0)
            $display("FAIL midseq_reset: ready=%b req=%b state=%0d tid=%h", host_ready, lc_transition_request_in, seq_state, lc_transition_id);
        else n_pass++;
        rst = 1'b0; #1;
        n_checks++;
        if ({host_ready, seq_state} !== {1'b1, 3'd0})
            $display("FAIL midseq_release: ready=%b state=%0d required 1/0", host_ready, seq_state);
        else n_pass++;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_abort();
        test_protocol();
        test_backpressure();
        test_midseq_reset();
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL missing_strobe: %0d expected strobes never seen", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
